// File: rtl/gelato_pkg.sv
// Shared types and constants for the gelato issue path: execution-unit codes
// and the width of the per-unit credit counters.
package gelato_pkg;

   typedef enum logic [1:0] {
      UNIT_MEM     = 2'd0,
      UNIT_COMPUTE = 2'd1,
      UNIT_TENSOR  = 2'd2,
      UNIT_NONE    = 2'd3
   } exec_unit_e;

   localparam int NUM_EXEC_UNITS = 3;
   localparam int CREDIT_W       = 3;

endpackage

// File: rtl/gelato_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// N must be a power of two so the index arithmetic wraps naturally.
module gelato_rr_picker
   import gelato_pkg::*;
#(
   parameter  int N  = 4,
   localparam int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] gnt_idx,
   output logic          any_gnt
);

   logic [PW-1:0] idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      idx     = '0;
      for (int k = 0; k < N; k++) begin
         idx = ptr + PW'(k);
         if (!any_gnt && req[idx]) begin
            any_gnt      = 1'b1;
            gnt_idx      = idx;
            gnt[idx]     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gelato_issue_arbiter.sv
// Credit-gated round-robin issue arbiter feeding a one-entry output register.
// Optional perf counters are compiled in with GELATO_ISSUE_PERF_EN.
module gelato_issue_arbiter
   import gelato_pkg::*;
#(
   parameter  int NUM_WARPS       = 4,
   parameter  int INST_WIDTH      = 64,
   parameter  int CREDITS_MEM     = 2,
   parameter  int CREDITS_COMPUTE = 4,
   parameter  int CREDITS_TENSOR  = 1,
   localparam int WARP_ID_WIDTH   = $clog2(NUM_WARPS)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            rdy,
   input  logic [NUM_WARPS-1:0]            warp_valid,
   input  logic [2*NUM_WARPS-1:0]          warp_unit,
   input  logic [INST_WIDTH*NUM_WARPS-1:0] warp_inst,
   output logic [NUM_WARPS-1:0]            warp_grant,
   output logic                            issue_valid,
   input  logic                            issue_ready,
   output logic [WARP_ID_WIDTH-1:0]        issue_warp_id,
   output logic [1:0]                      issue_unit,
   output logic [INST_WIDTH-1:0]           issue_inst,
   input  logic [2:0]                      credit_return,
   output logic [2:0]                      unit_busy
`ifdef GELATO_ISSUE_PERF_EN
   ,
   output logic [31:0]                     perf_issue_count,
   output logic [31:0]                     perf_stall_count
`endif
);

   typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e;

   slot_state_e              slot_state;
   logic [CREDIT_W-1:0]      credit [NUM_EXEC_UNITS];
   logic [WARP_ID_WIDTH-1:0] rr_ptr;
   logic [WARP_ID_WIDTH-1:0] pick_idx;
   logic [NUM_WARPS-1:0]     eligible;
   logic [NUM_WARPS-1:0]     pick_gnt;
   logic                     pick_any;
   logic                     slot_free;
   logic                     grant_fire;
   logic [3:0]               unit_avail;
   logic [2:0]               unit_take;
   logic [1:0]               grant_unit;
   logic [INST_WIDTH-1:0]    grant_inst;

   function automatic logic [CREDIT_W-1:0] credit_cap(input int u);
      case (u)
         0:       credit_cap = CREDIT_W'(CREDITS_MEM);
         1:       credit_cap = CREDIT_W'(CREDITS_COMPUTE);
         default: credit_cap = CREDIT_W'(CREDITS_TENSOR);
      endcase
   endfunction

   // A same-cycle return makes a drained unit usable; code 3 is never available.
   always_comb begin
      unit_avail = '0;
      for (int u = 0; u < NUM_EXEC_UNITS; u++)
         unit_avail[u] = (credit[u] != '0) || credit_return[u];
   end

   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_WARPS; i++)
         eligible[i] = warp_valid[i] && unit_avail[warp_unit[2*i +: 2]];
   end

   gelato_rr_picker #(.N(NUM_WARPS)) u_picker (
      .req     (eligible),
      .ptr     (rr_ptr),
      .gnt     (pick_gnt),
      .gnt_idx (pick_idx),
      .any_gnt (pick_any)
   );

   assign slot_free  = !issue_valid || issue_ready;
   assign grant_fire = rdy && slot_free && pick_any;
   assign warp_grant = grant_fire ? pick_gnt : '0;
   assign grant_unit = warp_unit[{pick_idx, 1'b0} +: 2];

   always_comb begin
      grant_inst = '0;
      for (int i = 0; i < NUM_WARPS; i++)
         if (WARP_ID_WIDTH'(i) == pick_idx)
            grant_inst = warp_inst[i*INST_WIDTH +: INST_WIDTH];
   end

   always_comb begin
      unit_take = '0;
      for (int u = 0; u < NUM_EXEC_UNITS; u++)
         unit_take[u] = grant_fire && (grant_unit == 2'(u));
   end

   always_comb begin
      unit_busy = '0;
      for (int u = 0; u < NUM_EXEC_UNITS; u++)
         unit_busy[u] = (credit[u] == '0);
   end

   // Take plus return on one unit cancels; returns at the cap are dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int u = 0; u < NUM_EXEC_UNITS; u++)
            credit[u] <= credit_cap(u);
      end else if (rdy) begin
         for (int u = 0; u < NUM_EXEC_UNITS; u++) begin
            if (unit_take[u] && !credit_return[u])
               credit[u] <= credit[u] - CREDIT_W'(1);
            else if (!unit_take[u] && credit_return[u] && credit[u] != credit_cap(u))
               credit[u] <= credit[u] + CREDIT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot_state    <= SLOT_EMPTY;
         issue_valid   <= 1'b0;
         issue_warp_id <= '0;
         issue_unit    <= '0;
         issue_inst    <= '0;
         rr_ptr        <= '0;
      end else if (rdy) begin
         case (slot_state)
            SLOT_EMPTY: begin
               if (grant_fire) begin
                  slot_state  <= SLOT_FULL;
                  issue_valid <= 1'b1;
               end
            end
            default: begin
               if (!grant_fire && issue_ready) begin
                  slot_state  <= SLOT_EMPTY;
                  issue_valid <= 1'b0;
               end
            end
         endcase
         if (grant_fire) begin
            issue_warp_id <= pick_idx;
            issue_unit    <= grant_unit;
            issue_inst    <= grant_inst;
            rr_ptr        <= pick_idx + WARP_ID_WIDTH'(1);
         end
      end
   end

`ifdef GELATO_ISSUE_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_issue_count <= '0;
         perf_stall_count <= '0;
      end else if (rdy) begin
         if (grant_fire)
            perf_issue_count <= perf_issue_count + 32'd1;
         else if (|warp_valid)
            perf_stall_count <= perf_stall_count + 32'd1;
      end
   end
`endif

endmodule
